// File: rtl/fml_arbiter2_if.sv
// Bus bundle between two FML masters, the arbiter and the shared FML slave port.
// The slave modport is the arbiter's view; master is the view of whatever drives the masters and FML slave.
interface fml_arbiter2_if #(
  parameter int sdram_depth = 26
);
  logic [sdram_depth-1:0] m0_adr;
  logic                   m0_stb;
  logic                   m0_we;
  logic [3:0]             m0_sel;
  logic [31:0]            m0_do;
  logic                   m0_ack;

  logic [sdram_depth-1:0] m1_adr;
  logic                   m1_stb;
  logic                   m1_we;
  logic [3:0]             m1_sel;
  logic [31:0]            m1_do;
  logic                   m1_ack;

  logic [31:0]            m_di;

  logic [sdram_depth-1:0] fml_adr;
  logic                   fml_stb;
  logic                   fml_we;
  logic [3:0]             fml_sel;
  logic [31:0]            fml_do;
  logic                   fml_ack;
  logic [31:0]            fml_di;

  modport slave (
    input  m0_adr, m0_stb, m0_we, m0_sel, m0_do,
    input  m1_adr, m1_stb, m1_we, m1_sel, m1_do,
    input  fml_ack, fml_di,
    output m0_ack, m1_ack, m_di,
    output fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );

  modport master (
    output m0_adr, m0_stb, m0_we, m0_sel, m0_do,
    output m1_adr, m1_stb, m1_we, m1_sel, m1_do,
    output fml_ack, fml_di,
    input  m0_ack, m1_ack, m_di,
    input  fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );
endinterface

// File: rtl/fml_arbiter2.sv
// Round-robin arbiter sharing one FML port between two masters, one transaction in flight.
// After each ack the grant is held for burst_cycles data-phase cycles so the owner's data is routed.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate among held strobes
//   REQ    | owner's strobe forwarded to FML, waiting for fml_ack
//   DATA   | burst data phase; strobe off, mux held on owner for burst_cycles cycles
module fml_arbiter2 #(
  parameter int sdram_depth  = 26,
  parameter int burst_cycles = 4
) (
  input  logic           clk_sys_i,
  input  logic           rst_n_i,
  fml_arbiter2_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [3:0] LP_CNT_LAST = 4'(burst_cycles - 1);

  logic [1:0] r_state;
  logic       r_gnt;
  logic       r_last;
  logic [3:0] r_cnt;

  logic [sdram_depth-1:0] w_adr_g;
  logic                   w_stb_g;
  logic                   w_we_g;
  logic [3:0]             w_sel_g;
  logic [31:0]            w_do_g;
  logic                   w_owned;

  always_comb begin
    w_adr_g = r_gnt ? bus.m1_adr : bus.m0_adr;
    w_stb_g = r_gnt ? bus.m1_stb : bus.m0_stb;
    w_we_g  = r_gnt ? bus.m1_we  : bus.m0_we;
    w_sel_g = r_gnt ? bus.m1_sel : bus.m0_sel;
    w_do_g  = r_gnt ? bus.m1_do  : bus.m0_do;
  end

  assign w_owned = (r_state == S_REQ) || (r_state == S_DATA);

  assign bus.fml_adr = w_adr_g;
  assign bus.fml_we  = w_we_g;
  assign bus.fml_do  = w_do_g;
  // Byte enables are masked whenever nobody owns the port, so no stray write lanes leak out.
  assign bus.fml_sel = w_owned ? w_sel_g : 4'h0;
  assign bus.fml_stb = (r_state == S_REQ) && w_stb_g;

  assign bus.m0_ack = bus.fml_ack && (r_state == S_REQ) && !r_gnt;
  assign bus.m1_ack = bus.fml_ack && (r_state == S_REQ) &&  r_gnt;
  assign bus.m_di   = bus.fml_di;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.m0_stb && bus.m1_stb) begin
            r_gnt   <= ~r_last;
            r_state <= S_REQ;
          end else if (bus.m0_stb) begin
            r_gnt   <= 1'b0;
            r_state <= S_REQ;
          end else if (bus.m1_stb) begin
            r_gnt   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.fml_ack) begin
            r_last  <= r_gnt;
            r_cnt   <= 4'd0;
            r_state <= S_DATA;
          end else if (!w_stb_g) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LP_CNT_LAST) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fml_arbiter2.md
Name: fml_arbiter2

Overview:
- Two-master arbiter sharing one FML (SDRAM) port, for example between the Wishbone-to-FML bridge (CPU) and the display framebuffer fetch engine.
- Round-robin grant with a single outstanding transaction.
- After each FML ack, the grant is held for a fixed number of data-phase cycles so the owner's burst data (fml_do/fml_sel) is routed cleanly.
- Read data fml_di is broadcast to both masters.

Parameters:
sdram_depth, 26, FML address width
burst_cycles, 4, data-phase cycles after ack during which the grant is held (range 1..15)

Ports:
clk_sys_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
m0_adr  in  sdram_depth  master 0 address
m0_stb  in  1  master 0 request strobe
m0_we  in  1  master 0 write enable
m0_sel  in  4  master 0 byte select
m0_do  in  32  master 0 write data
m0_ack  out  1  master 0 acknowledge
m1_adr  in  sdram_depth  master 1 address
m1_stb  in  1  master 1 request strobe
m1_we  in  1  master 1 write enable
m1_sel  in  4  master 1 byte select
m1_do  in  32  master 1 write data
m1_ack  out  1  master 1 acknowledge
m_di  out  32  read data to both masters (= fml_di, combinational)
fml_adr  out  sdram_depth  FML address
fml_stb  out  1  FML strobe
fml_we  out  1  FML write enable
fml_sel  out  4  FML byte select
fml_do  out  32  FML write data
fml_ack  in  1  FML acknowledge
fml_di  in  32  FML read data

Behaviour:
- Clock and reset: single clock clk_sys_i; reset rst_n_i is asynchronous and active-low. All registers clear on reset.
- Registered state:
  - state: IDLE, REQ, DATA.
  - gnt: 1 bit, selected master.
  - last: 1 bit, last served master; reset value 1, so m0 wins the first tie.
  - cnt: 4 bits.
- Reset values: state=IDLE, gnt=0, cnt=0.
  - Outputs during reset: fml_stb=0, m0_ack=0, m1_ack=0.
  - fml_adr/fml_we/fml_sel/fml_do follow master 0, with fml_sel forced to 0.
- Output mux (combinational):
  - fml_adr, fml_we and fml_do come from master gnt.
  - fml_sel comes from master gnt in REQ and DATA, and is 0 in IDLE.
- fml_stb = (state==REQ) && stb of master gnt.
- Ack routing: mX_ack = fml_ack && state==REQ && gnt==X. Ack is combinational, so it occurs in the same cycle as fml_ack.
- IDLE:
  - Only m0_stb: gnt<=0, go to REQ.
  - Only m1_stb: gnt<=1, go to REQ.
  - Both: gnt<=~last, go to REQ.
  - Neither: stay in IDLE.
  - Grant latency: a request seen in cycle N produces fml_stb high in cycle N+1.
- REQ:
  - fml_ack=1: last<=gnt, cnt<=0, go to DATA.
  - Granted stb deasserted before ack (abort): fml_stb drops in the same cycle, return to IDLE next cycle, last unchanged.
- DATA:
  - fml_stb=0; the mux stays on gnt so the owner supplies write data and sel.
  - cnt increments each cycle. When cnt==burst_cycles-1, go to IDLE.
  - DATA therefore lasts exactly burst_cycles cycles.
  - fml_ack seen in DATA is ignored; no mX_ack is generated.
- Re-arbitration: the first opportunity to issue again is the IDLE cycle after DATA. An ack-to-next-fml_stb gap is therefore burst_cycles+2 cycles.
  - Minimum issue spacing is one IDLE cycle; back-to-back acks are never issued.
- Fairness: with both masters requesting continuously, grants strictly alternate.
- Request timing: a request that arrives while the other master is in REQ or DATA waits in IDLE arbitration. Requests are not latched; the master must hold stb, as FML requires.
- Reset mid-transaction: the asynchronous clear returns the block to IDLE immediately and drops fml_stb. No ack is produced.

Test Plan:
- Reset release, m0_stb=1 only (adr=0x100, we=0), slave acks 2 cycles later:
  - fml_stb high from cycle 1 with fml_adr=0x100.
  - m0_ack pulses coincident with fml_ack; m1_ack stays 0.
  - fml_stb stays low for 4 DATA cycles plus 1 IDLE cycle.
- m0_stb and m1_stb both held high for 6 transactions, slave acks immediately:
  - Grant order 0,1,0,1,0,1.
  - Each master receives exactly 3 acks.
- m1 write (sel=0xF, do=0xDEADBEEF) granted, m0 requests during m1's DATA phase:
  - fml_do=0xDEADBEEF and fml_sel=0xF throughout all 4 DATA cycles.
  - m0 gets fml_stb only after DATA completes.
- m0 granted, m0 drops stb before any ack, m1_stb high:
  - fml_stb drops in the same cycle.
  - m1 is granted on the following IDLE cycle.
  - No ack is issued to either master.
- rst_n_i asserted mid-REQ:
  - fml_stb=0 and both acks 0 immediately (asynchronously).
  - After release, m0 wins the first tie.
- burst_cycles=1, m0 streaming, fml_ack asserted for 2 consecutive cycles:
  - The second fml_ack falls in DATA and generates no m0_ack.
  - The next fml_stb appears 3 cycles after the first ack.
